osd_spi_seq: RTL and testbench
==============================

// Module: osd_spi_seq
// PURPOSE
// Command sequencer that drives the OSD overlay's SPI client (SPI_SCK/SPI_SS3/SPI_DI).
// Accepts enable/disable/write-line requests from a local menu controller, frames each request
// as one SS3-low SPI transaction, and streams the 256 payload bytes of a line write out of a
// local 1-cycle-latency byte RAM. Sits between the menu/firmware logic and the OSD block.
// PARAMETERS
// CLK_DIV   2    clk cycles per SCK half-period; legal range >=2
// GAP_HALF  2    SS3-high gap between transactions, in SCK half-periods (>=1)
// PORTS
// clk        in   1  system clock; all logic on rising edge
// reset      in   1  asynchronous, active-high reset
// cmd_valid  in   1  request present; hold with cmd_op/cmd_line stable until accepted
// cmd_ready  out  1  sequencer idle; request accepted when cmd_valid & cmd_ready
// cmd_op     in   2  0=disable, 1=enable, 2=write line, 3=reserved (accepted, no SPI activity)
// cmd_line   in   3  OSD line (0..7) for write; ignored otherwise
// data_rd    out  1  one-cycle read strobe to payload RAM
// data_addr  out  8  payload byte index 0..255 for current write
// data_rdata in   8  payload byte; valid exactly 1 clk after data_rd
// busy       out  1  transaction in progress (not idle)
// done       out  1  one-cycle pulse when a transaction's gap ends
// SPI_SCK    out  1  serial clock, idles low
// SPI_SS3    out  1  OSD select, active low, idles high
// SPI_DI     out  1  serial data, MSB first, changes only while SCK low
// BEHAVIOUR
// Reset values: cmd_ready=1, busy=0, done=0, data_rd=0, data_addr=0, SCK=0, SS3=1, DI=0.
// Command byte: disable=8'h40, enable=8'h41, write=8'h20|cmd_line. Write adds 256 payload bytes.
// States: IDLE -> SHIFT -> HOLD -> GAP -> IDLE. Op 3 goes IDLE->GAP (no SS3 activity).
// Accept at cycle T: T+1 SS3=0, SCK=0, DI=cmd[7], busy=1, cmd_ready=0.
// Each bit lasts 2*CLK_DIV clks: SCK rises CLK_DIV clks after DI set, falls CLK_DIV clks later;
//   next bit's DI presented on the same clk SCK falls.
// After final falling edge: HOLD CLK_DIV clks (SS3 low, SCK low), then SS3=1;
//   GAP GAP_HALF*CLK_DIV clks; done=1 on last GAP clk; cmd_ready=1 the clk after.
// Enable, CLK_DIV=2, GAP_HALF=2: SS3 low T+1..T+34, done at T+38, cmd_ready=1 at T+39.
// Write payload: byte 0 fetched (data_rd, addr 0) during command byte's first bit; byte n+1
//   fetched when byte n loads into shifter; fetched byte held in a 1-entry prefetch register.
//   Exactly 256 data_rd pulses per write, addresses 0..255 ascending, no repeats or gaps.
// Bit counter 3 bits; byte counter 9 bits (0=cmd, 1..256=payload); wrap of data_addr at 255 is
//   not reached (fetch stops after 255).
// cmd_valid while busy: ignored; cmd_ready stays 0; inputs not sampled until IDLE.
// Reset mid-transaction: outputs to reset values asynchronously; SS3 rising resets OSD client
//   counters, so partial line write leaves earlier bytes written, later ones untouched.
// cmd_op/cmd_line captured at accept; later changes have no effect on the transaction.
// STRUCTURE
// osd_defs.vh: localparams OP_DISABLE/OP_ENABLE/OP_WRITE, CMD_ENABLE_BASE=8'h40,
//   CMD_WRITE_BASE=8'h20, OSD_LINE_BYTES=256; shared with the OSD block and menu controller.
// Sub-module osd_spi_shift: CLK_DIV half-period timer + 8-bit MSB-first shifter with
//   load/byte_done handshake; top holds FSM, byte counter and RAM prefetch.
// TESTING
// Reset, then enable (CLK_DIV=2) -> SCK sees 8 rising edges, DI samples 0x41, SS3 low T+1..T+34.
// Disable -> sampled byte 0x40; done one pulse; cmd_ready back at T+39.
// Write line 5, RAM[i]=i^8'hA5 -> cmd 0x25 then 256 bytes matching RAM, 256 data_rd, addr 0..255.
// Back-to-back cmd_valid held high, enable then write -> SS3 high >= GAP_HALF*CLK_DIV clks between.
// Assert reset at payload byte 100 -> SS3=1, SCK=0 same cycle; post-reset write completes cleanly.
// cmd_op=3 -> no SCK edges, SS3 stays 1, done pulses, cmd_ready returns.

Source files
------------

// File: rtl/osd_spi_seq_pkg.sv
// osd_spi_seq_pkg: OSD SPI opcodes, command bytes and sequencer state encoding
package osd_spi_seq_pkg;
    localparam logic [1:0] OP_DISABLE      = 2'd0;
    localparam logic [1:0] OP_ENABLE       = 2'd1;
    localparam logic [1:0] OP_WRITE        = 2'd2;
    localparam logic [1:0] OP_RSVD         = 2'd3;
    localparam logic [7:0] CMD_ENABLE_BASE = 8'h40;
    localparam logic [7:0] CMD_WRITE_BASE  = 8'h20;
    localparam int         OSD_LINE_BYTES  = 256;

    // bit 1 set exactly in the states that hold SS3 low, so SS3 is a clean flop bit
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GAP   = 2'b01,
        ST_SHIFT = 2'b10,
        ST_HOLD  = 2'b11
    } state_t;

    function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [2:0] line);
        return op == OP_WRITE ? (CMD_WRITE_BASE | {5'd0, line})
                              : (CMD_ENABLE_BASE | {7'd0, op == OP_ENABLE});
    endfunction
endpackage

// File: rtl/osd_spi_shift.sv
// osd_spi_shift: SCK half-period timer and MSB-first byte shifter with back-to-back reload
module osd_spi_shift #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       more,
    input  logic [7:0] next_byte,
    output logic       byte_done,
    output logic       sck,
    output logic       di
);
    localparam int TW = $clog2(CLK_DIV);
    logic          run;
    logic          tick;
    logic [TW-1:0] tcnt;
    logic [2:0]    bitc;
    logic [7:0]    sreg;

    assign tick      = tcnt == TW'(CLK_DIV - 1);
    assign byte_done = run & sck & tick & (bitc == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run  <= 1'b0;
            tcnt <= '0;
            bitc <= '0;
            sreg <= '0;
            sck  <= 1'b0;
            di   <= 1'b0;
        end else if (load) begin
            run  <= 1'b1;
            tcnt <= '0;
            bitc <= '0;
            sreg <= din;
            sck  <= 1'b0;
            di   <= din[7];
        end else if (run) begin
            tcnt <= tick ? '0 : tcnt + 1'b1;
            if (tick) begin
                sck  <= ~sck;
                bitc <= sck ? bitc + 3'd1 : bitc;
                // next bit (or next byte's MSB) goes out on the same clk SCK falls
                if (sck && bitc == 3'd7) begin
                    run  <= more;
                    sreg <= next_byte;
                    di   <= more ? next_byte[7] : di;
                end else if (sck) begin
                    sreg <= {sreg[6:0], 1'b0};
                    di   <= sreg[6];
                end
            end
        end
    end
endmodule

// File: rtl/osd_spi_seq.sv
// osd_spi_seq: frames OSD enable/disable/line-write requests as SS3-low SPI transactions,
// streaming line payload from a 1-cycle-latency byte RAM through a one-entry prefetch.
module osd_spi_seq
    import osd_spi_seq_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int GAP_HALF = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_line,
    output logic       data_rd,
    output logic [7:0] data_addr,
    input  logic [7:0] data_rdata,
    output logic       busy,
    output logic       done,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI
);
    localparam int GAP_LEN = GAP_HALF * CLK_DIV;
    localparam int CW      = $clog2(GAP_LEN + CLK_DIV);

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic [8:0]    bcnt;
    logic [7:0]    pf;
    logic          is_wr, rd_q, byte_done, more, fetch, accept, load;

    assign accept    = cmd_valid & cmd_ready;
    assign load      = accept & (cmd_op != OP_RSVD);
    assign cmd_ready = state == ST_IDLE;
    assign busy      = state != ST_IDLE;
    assign done      = state == ST_GAP && cnt == CW'(GAP_LEN - 1);
    assign SPI_SS3   = ~state[1];
    assign more      = is_wr & (bcnt != 9'(OSD_LINE_BYTES));
    // byte n+1 is fetched as byte n enters the shifter; the last fetch is byte 255
    assign fetch     = byte_done & more & (bcnt < 9'd255);

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  state_d = accept ? (load ? ST_SHIFT : ST_GAP) : ST_IDLE;
            ST_SHIFT: state_d = byte_done && !more ? ST_HOLD : ST_SHIFT;
            ST_HOLD:  state_d = cnt == CW'(CLK_DIV - 1) ? ST_GAP : ST_HOLD;
            ST_GAP:   state_d = done ? ST_IDLE : ST_GAP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bcnt      <= '0;
            pf        <= '0;
            is_wr     <= 1'b0;
            rd_q      <= 1'b0;
            data_rd   <= 1'b0;
            data_addr <= '0;
        end else begin
            state     <= state_d;
            cnt       <= state_d != state ? '0 : cnt + 1'b1;
            is_wr     <= accept ? cmd_op == OP_WRITE : is_wr;
            bcnt      <= accept ? '0 : (byte_done && more) ? bcnt + 9'd1 : bcnt;
            data_rd   <= (accept && cmd_op == OP_WRITE) || fetch;
            data_addr <= accept ? '0 : fetch ? bcnt[7:0] + 8'd1 : data_addr;
            rd_q      <= data_rd;
            pf        <= rd_q ? data_rdata : pf;
        end
    end

    osd_spi_shift #(.CLK_DIV(CLK_DIV)) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .din       (cmd_byte(cmd_op, cmd_line)),
        .more      (more),
        .next_byte (pf),
        .byte_done (byte_done),
        .sck       (SPI_SCK),
        .di        (SPI_DI)
    );
endmodule

// File: tb/tb_osd_spi_seq.sv
// tb_osd_spi_seq: vector table of commands plus hand-written back-to-back and mid-write reset
// sequences; SPI bytes are checked against a queue of expected bytes filled at drive time.
module tb_osd_spi_seq;
    import osd_spi_seq_pkg::*;

    typedef struct {
        logic [1:0] op;
        logic [2:0] line;
        logic [7:0] cmd;
        int         first_lo;
        int         last_lo;
        int         done_k;
        int         ready_k;
        int         rises;
        int         nrd;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_line = 3'd0;
    logic [7:0] data_rdata = 8'd0;
    logic       cmd_ready, data_rd, busy, done, SPI_SCK, SPI_SS3, SPI_DI;
    logic [7:0] data_addr;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    int         exp_addr = 0;
    int         rd_cnt = 0;
    int         nbit = 0;
    logic [7:0] shreg = 8'd0;
    logic       sck_p = 1'b0;
    logic       di_p = 1'b0;
    vec_t       vecs [5];

    osd_spi_seq #(.CLK_DIV(2), .GAP_HALF(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_line   (cmd_line),
        .data_rd    (data_rd),
        .data_addr  (data_addr),
        .data_rdata (data_rdata),
        .busy       (busy),
        .done       (done),
        .SPI_SCK    (SPI_SCK),
        .SPI_SS3    (SPI_SS3),
        .SPI_DI     (SPI_DI)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // payload RAM: junk unless a read was strobed the cycle before
    always @(posedge clk) data_rdata <= data_rd ? mem[data_addr] : 8'($urandom);

    always @(negedge clk) begin
        if (!reset && data_rd) begin
            check("rd_addr", {24'd0, data_addr}, exp_addr);
            exp_addr++;
            rd_cnt++;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            nbit  = 0;
            sck_p = 1'b0;
        end else begin
            if (SPI_SCK && sck_p) check("di_stable", SPI_DI, di_p);
            if (SPI_SCK && !sck_p) begin
                check("sck_under_ss3", SPI_SS3, 0);
                shreg = {shreg[6:0], SPI_DI};
                nbit++;
                if (nbit == 8) begin
                    nbit = 0;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL spi_extra_byte: got 0x%0h, expected no byte", shreg);
                    end else begin
                        n_checks--;
                        check("spi_byte", shreg, exp_q.pop_front());
                    end
                end
            end
            sck_p = SPI_SCK;
            di_p  = SPI_DI;
        end
    end

    task automatic push_expected(input logic [1:0] op, input logic [7:0] cmd);
        if (op != OP_RSVD) exp_q.push_back(cmd);
        if (op == OP_WRITE) for (int i = 0; i < 256; i++) exp_q.push_back(mem[i]);
    endtask

    task automatic run_cmd(input vec_t v);
        int   k = 0, first_lo = 0, last_lo = 0, done_k = 0, ready_k = 0, ndone = 0, rises = 0;
        logic sp = 1'b0;
        exp_addr = 0;
        rd_cnt   = 0;
        push_expected(v.op, v.cmd);
        @(negedge clk);
        check("ready_pre", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_line  = v.line;
        @(posedge clk);
        while (ready_k == 0 && k < 10000) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                cmd_valid = 1'b0;
                cmd_op    = v.op ^ 2'b01;
                cmd_line  = ~v.line;
                check("busy_t1", busy, 1);
                check("ready_t1", cmd_ready, 0);
            end
            if (!SPI_SS3) begin
                if (first_lo == 0) first_lo = k;
                last_lo = k;
            end
            if (SPI_SCK && !sp) rises++;
            sp = SPI_SCK;
            if (done) begin
                ndone++;
                done_k = k;
            end
            if (cmd_ready) ready_k = k;
        end
        check("ss3_first_low", first_lo, v.first_lo);
        check("ss3_last_low", last_lo, v.last_lo);
        check("done_cycle", done_k, v.done_k);
        check("done_pulses", ndone, 1);
        check("ready_cycle", ready_k, v.ready_k);
        check("sck_rises", rises, v.rises);
        check("rd_count", rd_cnt, v.nrd);
        check("bytes_left", exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, gap, hi, k;
        logic seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        vecs[0] = '{OP_ENABLE,  3'd0, 8'h41, 1, 34,   38,   39,   8,    0};
        vecs[1] = '{OP_DISABLE, 3'd6, 8'h40, 1, 34,   38,   39,   8,    0};
        vecs[2] = '{OP_WRITE,   3'd5, 8'h25, 1, 8226, 8230, 8231, 2056, 256};
        vecs[3] = '{OP_RSVD,    3'd2, 8'h00, 0, 0,    4,    5,    0,    0};
        vecs[4] = '{OP_WRITE,   3'd7, 8'h27, 1, 8226, 8230, 8231, 2056, 256};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data_rd", data_rd, 0);
        check("rst_addr", data_addr, 0);
        check("rst_sck", SPI_SCK, 0);
        check("rst_ss3", SPI_SS3, 1);
        check("rst_di", SPI_DI, 0);

        for (int i = 0; i < 5; i++) run_cmd(vecs[i]);

        // back-to-back: valid held high across enable then write line 5
        exp_addr = 0;
        rd_cnt   = 0;
        push_expected(OP_ENABLE, 8'h41);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_ENABLE;
        cmd_line  = 3'd0;
        @(posedge clk);
        seen = 1'b0;
        hi   = 0;
        gap  = -1;
        k    = 0;
        while (gap < 0 && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                cmd_op   = OP_WRITE;
                cmd_line = 3'd5;
                push_expected(OP_WRITE, 8'h25);
            end
            if (!SPI_SS3) begin
                if (hi > 0) gap = hi;
                seen = 1'b1;
            end else if (seen) hi++;
        end
        cmd_valid = 1'b0;
        check("b2b_gap", gap, 5);
        w = 0;
        while (!cmd_ready && w < 10000) begin
            @(negedge clk);
            w++;
        end
        check("b2b_ready", cmd_ready, 1);
        check("b2b_rd_count", rd_cnt, 256);
        check("b2b_bytes_left", exp_q.size(), 0);

        // reset while payload byte 100 is on the wire
        exp_addr = 0;
        rd_cnt   = 0;
        push_expected(OP_WRITE, 8'h23);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_line  = 3'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (exp_q.size() > 156 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        check("reach_byte100", exp_q.size(), 156);
        repeat (8) @(negedge clk);
        check("mid_rd_count", rd_cnt, 102);
        check("mid_ss3", SPI_SS3, 0);
        #2 reset = 1'b1;
        #1;
        check("arst_ss3", SPI_SS3, 1);
        check("arst_sck", SPI_SCK, 0);
        check("arst_ready", cmd_ready, 1);
        check("arst_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        run_cmd(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
